// File: rtl/bp_sacc_pkg.sv
// Shared types and constants for the sacc scratchpad arbiter.
package bp_sacc_pkg;

    // Requester identity; the value doubles as the per-port vector index
    typedef enum logic {
        e_sacc_port_ext = 1'b0,
        e_sacc_port_int = 1'b1
    } bp_sacc_port_e;

    // Byte address to 64b word index shift
    localparam int unsigned sacc_spm_word_shift_gp = 3;

    localparam int unsigned sacc_num_ports_gp = 2;

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous-read memory: one read or write per cycle, read data next cycle.
module bsg_mem_1rw_sync #(
    parameter int unsigned width_p      = 64,
    parameter int unsigned els_p        = 20,
    parameter int unsigned addr_width_p = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [width_p-1:0]      data_i,
    output logic [width_p-1:0]      data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // Storage write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            mem_r[addr_i] <= data_i;
        end
    end

    // Registered read port; holds its value when not reading
    always_ff @(posedge clk_i) begin
        if (v_i && !w_i) begin
            data_o <= mem_r[addr_i];
        end
    end

endmodule

// File: rtl/bp_sacc_spm_arbiter.sv
// Two-requester arbiter for the accelerator's single-port scratchpad.
// External IO port has fixed priority over the internal engine port.
// Optional feature macro: BP_SACC_SPM_ARB_STARVE_EN (bounded starvation of the internal port).
module bp_sacc_spm_arbiter
    import bp_sacc_pkg::*;
#(
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned els_p          = 20,
    parameter int unsigned addr_width_p   = 39,
    parameter int unsigned starve_limit_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    ext_v_i,
    input  logic                    ext_w_i,
    input  logic [addr_width_p-1:0] ext_addr_i,
    input  logic [data_width_p-1:0] ext_data_i,
    output logic                    ext_ready_o,
    output logic                    ext_resp_v_o,
    output logic [data_width_p-1:0] ext_resp_data_o,
    input  logic                    ext_resp_yumi_i,

    input  logic                    int_v_i,
    input  logic                    int_w_i,
    input  logic [addr_width_p-1:0] int_addr_i,
    input  logic [data_width_p-1:0] int_data_i,
    output logic                    int_ready_o,
    output logic                    int_resp_v_o,
    output logic [data_width_p-1:0] int_resp_data_o,
    input  logic                    int_resp_yumi_i
);

    localparam int unsigned lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned word_idx_w_lp = addr_width_p - sacc_spm_word_shift_gp;

    logic [sacc_num_ports_gp-1:0] v_li, w_li, yumi_li, in_range, elig, fire;
    logic [addr_width_p-1:0]      addr_li [sacc_num_ports_gp];
    logic [data_width_p-1:0]      data_li [sacc_num_ports_gp];

    logic [sacc_num_ports_gp-1:0] resp_v_q, pend_q;
    logic [data_width_p-1:0]      resp_data_q [sacc_num_ports_gp];

    logic                         force_int;
    bp_sacc_port_e                grant;

    logic                         mem_v, mem_w;
    logic [lg_els_lp-1:0]         mem_addr;
    logic [data_width_p-1:0]      mem_wdata, mem_rdata;

    assign v_li       = {int_v_i, ext_v_i};
    assign w_li       = {int_w_i, ext_w_i};
    assign yumi_li    = {int_resp_yumi_i, ext_resp_yumi_i};
    assign addr_li[0] = ext_addr_i;
    assign addr_li[1] = int_addr_i;
    assign data_li[0] = ext_data_i;
    assign data_li[1] = int_data_i;

    // Range check uses the full word index so high address bits cannot alias into the SPM
    always_comb begin
        in_range = '0;
        for (int p = 0; p < int'(sacc_num_ports_gp); p++) begin
            in_range[p] = addr_li[p][addr_width_p-1:sacc_spm_word_shift_gp] < word_idx_w_lp'(els_p);
        end
    end

    // Eligibility and grant: a port may issue when its response slot is free or freeing this cycle
    always_comb begin
        elig  = v_li & (~resp_v_q | yumi_li) & {sacc_num_ports_gp{~reset_i}};
        fire  = '0;
        grant = e_sacc_port_ext;
        if (elig[e_sacc_port_int] && (force_int || !elig[e_sacc_port_ext])) begin
            fire[e_sacc_port_int] = 1'b1;
            grant                 = e_sacc_port_int;
        end else if (elig[e_sacc_port_ext]) begin
            fire[e_sacc_port_ext] = 1'b1;
        end
    end

    // Steer the winner onto the SPM; out-of-range accesses never touch storage
    always_comb begin
        mem_w     = w_li[grant];
        mem_wdata = data_li[grant];
        mem_addr  = addr_li[grant][sacc_spm_word_shift_gp +: lg_els_lp];
        mem_v     = |(fire & in_range);
    end

    bsg_mem_1rw_sync #(
        .width_p      (data_width_p),
        .els_p        (els_p),
        .addr_width_p (lg_els_lp)
    ) spm (
        .clk_i  (clk_i),
        .v_i    (mem_v),
        .w_i    (mem_w),
        .addr_i (mem_addr),
        .data_i (mem_wdata),
        .data_o (mem_rdata)
    );

    // Response slots: valid flag, held data, and a pending flag meaning "data is on the SPM output now"
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_v_q <= '0;
            pend_q   <= '0;
            for (int p = 0; p < int'(sacc_num_ports_gp); p++) begin
                resp_data_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(sacc_num_ports_gp); p++) begin
                if (fire[p]) begin
                    resp_v_q[p]    <= 1'b1;
                    pend_q[p]      <= ~w_li[p] & in_range[p];
                    resp_data_q[p] <= '0;
                end else begin
                    if (yumi_li[p]) begin
                        resp_v_q[p] <= 1'b0;
                    end
                    if (pend_q[p]) begin
                        resp_data_q[p] <= mem_rdata;
                        pend_q[p]      <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef BP_SACC_SPM_ARB_STARVE_EN
    localparam int unsigned starve_w_lp = $clog2(starve_limit_p + 1);

    logic [starve_w_lp-1:0] starve_cnt_q;

    assign force_int = (starve_cnt_q == starve_w_lp'(starve_limit_p));

    // Saturating count of cycles the internal port was eligible but lost
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
        end else if (fire[e_sacc_port_int]) begin
            starve_cnt_q <= '0;
        end else if (elig[e_sacc_port_int] && !force_int) begin
            starve_cnt_q <= starve_cnt_q + starve_w_lp'(1);
        end
    end
`else
    logic unused_starve_limit;

    assign force_int           = 1'b0;
    assign unused_starve_limit = ^starve_limit_p;
`endif

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ext_addr_i[sacc_spm_word_shift_gp-1:0],
                                int_addr_i[sacc_spm_word_shift_gp-1:0]};

    assign ext_ready_o     = fire[e_sacc_port_ext];
    assign int_ready_o     = fire[e_sacc_port_int];
    assign ext_resp_v_o    = resp_v_q[e_sacc_port_ext];
    assign int_resp_v_o    = resp_v_q[e_sacc_port_int];
    assign ext_resp_data_o = pend_q[e_sacc_port_ext] ? mem_rdata : resp_data_q[e_sacc_port_ext];
    assign int_resp_data_o = pend_q[e_sacc_port_int] ? mem_rdata : resp_data_q[e_sacc_port_int];

`ifndef SYNTHESIS
    // A response may only be consumed while it is being presented
    ext_yumi_legal_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                       ext_resp_yumi_i |-> ext_resp_v_o);
    int_yumi_legal_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                       int_resp_yumi_i |-> int_resp_v_o);
`endif

endmodule
